// File: rtl/cond_if.sv
// Decoder-side bundle for the conditional-execution unit: the instruction
// condition, ALU flags and decoder strobes in, gated strobes and state out.
interface cond_if #(
  parameter int CNTW = 16
);
  logic            InstrValid;
  logic [3:0]      Cond;
  logic [3:0]      ALUFlags;
  logic [1:0]      FlagW;
  logic            PCS;
  logic            RegW;
  logic            MemW;
  logic            NoWrite;
  logic            CondEx;
  logic            PCSrc;
  logic            RegWrite;
  logic            MemWrite;
  logic [3:0]      Flags;
  logic [CNTW-1:0] ExecCount;
  logic [CNTW-1:0] SquashCount;

  // decoder side: drives the instruction, observes the gated result
  modport master (
    output InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  CondEx, PCSrc, RegWrite, MemWrite, Flags, ExecCount, SquashCount
  );

  // conditional unit side
  modport slave (
    input  InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output CondEx, PCSrc, RegWrite, MemWrite, Flags, ExecCount, SquashCount
  );
endinterface

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds the architectural NZCV register,
// evaluates the ARM-style condition field against it, gates the decoder
// strobes and counts executed / squashed instructions (saturating).
module cond_unit #(
  parameter int CNTW = 16
) (
  input logic   clk,
  input logic   reset,
  cond_if.slave bus
);

  logic [3:0]      flags_r;
  logic [CNTW-1:0] exec_r;
  logic [CNTW-1:0] squash_r;

  logic            cond_ex_s;
  logic            pcsrc_s;
  logic            regwrite_s;
  logic            memwrite_s;
  logic [CNTW:0]   exec_inc_s;
  logic [CNTW:0]   squash_inc_s;

  // Condition check against the stored flags {N,Z,C,V}; code 1111 never passes.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic pass;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  // Condition and gated strobes; only registered flags feed the check, so a
  // flag write is seen by the next instruction, never the current one.
  always_comb begin
    cond_ex_s  = cond_eval(bus.Cond, flags_r);
    pcsrc_s    = bus.InstrValid & cond_ex_s & bus.PCS;
    regwrite_s = bus.InstrValid & cond_ex_s & bus.RegW & ~bus.NoWrite;
    memwrite_s = bus.InstrValid & cond_ex_s & bus.MemW;
  end

  // One-bit-wider increments; the carry out marks the saturation point.
  always_comb begin
    exec_inc_s   = {1'b0, exec_r}   + {{CNTW{1'b0}}, 1'b1};
    squash_inc_s = {1'b0, squash_r} + {{CNTW{1'b0}}, 1'b1};
  end

  // Flag register and counters; reset wins, idle cycles change nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r  <= 4'b0000;
      exec_r   <= {CNTW{1'b0}};
      squash_r <= {CNTW{1'b0}};
    end else if (bus.InstrValid) begin
      if (cond_ex_s) begin
        if (bus.FlagW[1]) begin
          flags_r[3:2] <= bus.ALUFlags[3:2];
        end
        if (bus.FlagW[0]) begin
          flags_r[1:0] <= bus.ALUFlags[1:0];
        end
        if (!exec_inc_s[CNTW]) begin
          exec_r <= exec_inc_s[CNTW-1:0];
        end
      end else begin
        if (!squash_inc_s[CNTW]) begin
          squash_r <= squash_inc_s[CNTW-1:0];
        end
      end
    end
  end

  assign bus.CondEx      = cond_ex_s;
  assign bus.PCSrc       = pcsrc_s;
  assign bus.RegWrite    = regwrite_s;
  assign bus.MemWrite    = memwrite_s;
  assign bus.Flags       = flags_r;
  assign bus.ExecCount   = exec_r;
  assign bus.SquashCount = squash_r;

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit (CNTW=4): vector table, full condition sweep
// against an independent model, counter saturation and reset priority.
module tb_cond_unit;

  localparam int CNTW = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  cond_if #(.CNTW(CNTW)) bus ();

  cond_unit #(.CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [3:0] cond;
    logic [1:0] flagw;
    logic [3:0] alu;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       nowrite;
    logic       e_condex;
    logic       e_pcsrc;
    logic       e_regwrite;
    logic       e_memwrite;
    logic [3:0] e_flags;
    logic [3:0] e_exec;
    logic [3:0] e_squash;
  } vec_t;

  vec_t vt [19];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                       input logic [3:0] alu, input logic pcs, input logic regw,
                       input logic memw, input logic nowrite);
    bus.InstrValid = v;
    bus.Cond       = c;
    bus.FlagW      = fw;
    bus.ALUFlags   = alu;
    bus.PCS        = pcs;
    bus.RegW       = regw;
    bus.MemW       = memw;
    bus.NoWrite    = nowrite;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reference: ARM pairs conditions; odd codes invert the even one, 1111 never.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic base;
    case (c[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] & ~f[2];
      3'd5: base = ~(f[3] ^ f[0]);
      3'd6: base = ~f[2] & ~(f[3] ^ f[0]);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? ~base : base;
  endfunction

  initial begin
    total = 0;
    bad   = 0;

    //          v    cond     fw     alu      pcs  regw memw nowr  cex  pcs  rw   mw   flags    ex     sq
    vt[0]  = '{1'b1, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd0,  4'd1};
    vt[1]  = '{1'b1, 4'b0001, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'd1,  4'd1};
    vt[2]  = '{1'b1, 4'b1110, 2'b11, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 4'd2,  4'd1};
    vt[3]  = '{1'b1, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 4'd3,  4'd1};
    vt[4]  = '{1'b1, 4'b1000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 4'd3,  4'd2};
    vt[5]  = '{1'b1, 4'b1001, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 4'd4,  4'd2};
    vt[6]  = '{1'b1, 4'b1110, 2'b10, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 4'd5,  4'd2};
    vt[7]  = '{1'b1, 4'b1010, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 4'd5,  4'd3};
    vt[8]  = '{1'b1, 4'b1011, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 4'd6,  4'd3};
    vt[9]  = '{1'b1, 4'b0000, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 4'd6,  4'd4};
    vt[10] = '{1'b1, 4'b1110, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1010, 4'd7,  4'd4};
    vt[11] = '{1'b0, 4'b1110, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 4'd7,  4'd4};
    vt[12] = '{1'b1, 4'b1111, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 4'd7,  4'd5};
    vt[13] = '{1'b1, 4'b1100, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 4'd7,  4'd6};
    vt[14] = '{1'b1, 4'b1101, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 4'd8,  4'd6};
    vt[15] = '{1'b1, 4'b0100, 2'b01, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 4'd9,  4'd6};
    vt[16] = '{1'b1, 4'b0110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1001, 4'd10, 4'd6};
    vt[17] = '{1'b1, 4'b0011, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1001, 4'd11, 4'd6};
    vt[18] = '{1'b1, 4'b0111, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 4'd11, 4'd7};

    do_reset();
    check("reset_flags",  16'(bus.Flags), 16'h0);
    check("reset_exec",   16'(bus.ExecCount), 16'h0);
    check("reset_squash", 16'(bus.SquashCount), 16'h0);

    // table: combinational outputs mid-cycle, state after the edge
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].valid, vt[i].cond, vt[i].flagw, vt[i].alu,
            vt[i].pcs, vt[i].regw, vt[i].memw, vt[i].nowrite);
      @(negedge clk);
      check($sformatf("v%0d_condex", i),   16'(bus.CondEx),   16'(vt[i].e_condex));
      check($sformatf("v%0d_pcsrc", i),    16'(bus.PCSrc),    16'(vt[i].e_pcsrc));
      check($sformatf("v%0d_regwrite", i), 16'(bus.RegWrite), 16'(vt[i].e_regwrite));
      check($sformatf("v%0d_memwrite", i), 16'(bus.MemWrite), 16'(vt[i].e_memwrite));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_flags", i),  16'(bus.Flags),       16'(vt[i].e_flags));
      check($sformatf("v%0d_exec", i),   16'(bus.ExecCount),   16'(vt[i].e_exec));
      check($sformatf("v%0d_squash", i), 16'(bus.SquashCount), 16'(vt[i].e_squash));
    end

    // sweep: all 16 flag values x 16 conditions
    for (int f = 0; f < 16; f++) begin
      logic [3:0] fv;
      fv = 4'(f);
      do_reset();
      drive(1'b1, 4'b1110, 2'b11, fv, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("sweep_load_f%0d", f), 16'(bus.Flags), 16'(fv));
      for (int c = 0; c < 16; c++) begin
        logic [3:0] cv;
        cv = 4'(c);
        drive(1'b0, cv, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check($sformatf("sweep_f%0d_c%0d", f, c), 16'(bus.CondEx), 16'(ref_cond(cv, fv)));
      end
    end

    // saturation: 20 AL instructions, ExecCount stops at 15
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("sat_exec_%0d", i), 16'(bus.ExecCount), 16'((i + 1 > 15) ? 15 : i + 1));
    end
    check("sat_squash", 16'(bus.SquashCount), 16'h0);

    // squash saturation: 18 never-conditions
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 4'b1111, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    check("sat_squash_end", 16'(bus.SquashCount), 16'd15);
    check("sat_exec_hold",  16'(bus.ExecCount),   16'd15);

    // reset coincident with a passing flag write: reset wins
    drive(1'b1, 4'b1110, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_pri_flags",  16'(bus.Flags),       16'h0);
    check("rst_pri_exec",   16'(bus.ExecCount),   16'h0);
    check("rst_pri_squash", 16'(bus.SquashCount), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
Conditional-execution unit that consumes the 4-bit NZCV flag vector produced by the datapath ALU. It holds the architectural N/Z/C/V flag register and evaluates each instruction's 4-bit ARM-style condition field against the stored flags. It gates the decoder's write/branch strobes and keeps saturating executed and squashed instruction counters. It sits between the main decoder and the register file, memory write port and PC-select mux of the single-cycle core.

Parameters:
CNTW, 16, width of the executed and squashed instruction counters (saturating)

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
InstrValid  input  1  current-cycle instruction is valid
Cond  input  4  condition field of current instruction
ALUFlags  input  4  {N,Z,C,V} from ALU for current instruction
FlagW  input  2  FlagW[1] writes N,Z; FlagW[0] writes C,V
PCS  input  1  decoder PC-write request
RegW  input  1  decoder register-write request
MemW  input  1  decoder memory-write request
NoWrite  input  1  decoder suppresses RegWrite (CMP/TST style)
CondEx  output  1  condition passed for current instruction
PCSrc  output  1  gated PC-write strobe
RegWrite  output  1  gated register-write strobe
MemWrite  output  1  gated memory-write strobe
Flags  output  4  architectural {N,Z,C,V} register
ExecCount  output  CNTW  valid instructions with CondEx=1
SquashCount  output  CNTW  valid instructions with CondEx=0

Behaviour:
- Reset (synchronous, active-high; clk rising edge with reset=1): Flags=4'b0000, ExecCount=0, SquashCount=0. Reset has priority over any simultaneous flag write or count. Reset mid-stream discards the pending update.
- CondEx is combinational from registered Flags and Cond. Same-cycle ALUFlags never affect CondEx.
- Condition table (N,Z,C,V = Flags[3:0]):
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C&~Z. 1001 LS: ~C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: defined as never, so CondEx=0.
- Gated strobes are combinational, zero latency, and all are 0 when InstrValid=0:
  - PCSrc = InstrValid&CondEx&PCS
  - RegWrite = InstrValid&CondEx&RegW&~NoWrite
  - MemWrite = InstrValid&CondEx&MemW
- Flag register update at the clock edge, only when InstrValid&CondEx:
  - FlagW[1]=1: Flags[3:2] <= ALUFlags[3:2].
  - FlagW[0]=1: Flags[1:0] <= ALUFlags[1:0].
  - The two halves are independent; unwritten half holds.
  - A failed-condition instruction never modifies flags.
- Flag latency: flags written by instruction i are visible to CondEx for instruction i+1 on the next cycle. There is no bypass.
- Counters, each cycle with InstrValid=1:
  - CondEx=1: ExecCount increments.
  - CondEx=0: SquashCount increments.
  - Exactly one counter moves per valid instruction.
  - Both saturate at all-ones; no wrap.
  - InstrValid=0: both hold.
- X-safety: when InstrValid=0, no state changes regardless of other inputs.
- Internal structure: one 4-bit flag register and two CNTW counters. There is no FSM beyond the register state. Counter increments are computed at CNTW+1 bits, with the carry used for saturation.

Test Plan:
- Reset then Cond=0000, InstrValid=1, RegW=1 -> CondEx=0, RegWrite=0, SquashCount=1. Cond=0001 next cycle -> CondEx=1, RegWrite=1, ExecCount=1.
- Cond=1110, FlagW=2'b11, ALUFlags=4'b0110 -> Flags=0110 next cycle. Then Cond=0000 -> CondEx=1; Cond=1000 (HI) -> CondEx=0; Cond=1001 (LS) -> CondEx=1.
- Flags=0110, Cond=1110, FlagW=2'b10, ALUFlags=4'b1001 -> Flags=1010 (C,V held).
  - Then Cond=1010 (GE) -> CondEx=0 and Cond=1011 (LT) -> CondEx=1.
  - Also: a failed Cond with FlagW=2'b11 leaves Flags unchanged.
- Cond=1110 with PCS=1, MemW=1, RegW=1, NoWrite=1 -> PCSrc=1, MemWrite=1, RegWrite=0. Same inputs with InstrValid=0 -> all strobes 0, counters hold.
- Cond=1111 under every Flags value 0000..1111 -> CondEx=0. Sweep all 16 Cond x 16 Flags against a reference model.
- CNTW=4:
  - 20 consecutive AL instructions -> ExecCount stops at 15.
  - Assert reset in the same cycle as a flag write (ALUFlags=1111, FlagW=11) -> Flags=0000, ExecCount=0.
